// File: rtl/config_pkg.sv
// Shared frontend <-> icache fetch types. The frontend imports the same package.
package config_pkg;

    localparam int unsigned VLEN = 32;
    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic            req;
        logic            kill_s1;
        logic            kill_s2;
        logic            spec;
        logic [VLEN-1:0] vaddr;
    } icache_data_req_t;

    typedef struct packed {
        logic            ready;
        logic            valid;
        logic [XLEN-1:0] data;
        logic [VLEN-1:0] vaddr;
    } icache_data_res_t;

endpackage

// File: rtl/icache_dm_pkg.sv
// Local definitions for the direct-mapped icache: FSM states and address-split helpers.
package icache_dm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REFILL   = 2'd1,
        UNCACHED = 2'd2,
        RESP     = 2'd3
    } icacheState_e;

    function automatic int unsigned offBits(input int unsigned lineWords);
        return $clog2(lineWords * 4);
    endfunction

    function automatic int unsigned idxBits(input int unsigned numSets);
        return $clog2(numSets);
    endfunction

endpackage

// File: rtl/icache_dm_array.sv
// Flop-based tag/valid/data storage: combinational read, one write port, single-cycle invalidate-all.
module icache_array
    import icache_dm_pkg::*;
#(
    parameter int unsigned NUM_SETS   = 64,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned TAG_W      = 22,
    parameter int unsigned IDX_W      = idxBits(NUM_SETS)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic [IDX_W-1:0]             rdIdx_i,
    output logic                         rdValid_o,
    output logic [TAG_W-1:0]             rdTag_o,
    output logic [LINE_WORDS-1:0][31:0]  rdLine_o,
    input  logic                         we_i,
    input  logic [IDX_W-1:0]             wrIdx_i,
    input  logic [TAG_W-1:0]             wrTag_i,
    input  logic [LINE_WORDS-1:0][31:0]  wrLine_i
);

    logic [NUM_SETS-1:0]            valid_q;
    logic [TAG_W-1:0]               tag_q  [NUM_SETS];
    logic [LINE_WORDS-1:0][31:0]    data_q [NUM_SETS];

    // Invalidate-all wins over a same-cycle install so a fence.i is never undone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wrIdx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wrIdx_i]  <= wrTag_i;
            data_q[wrIdx_i] <= wrLine_i;
        end
    end

    assign rdValid_o = valid_q[rdIdx_i];
    assign rdTag_o   = tag_q[rdIdx_i];
    assign rdLine_o  = data_q[rdIdx_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped blocking L1 instruction cache between the frontend and the memory interconnect.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int unsigned NUM_SETS   = 64,
    parameter int unsigned LINE_WORDS = 4,
    parameter type icache_data_req_t  = config_pkg::icache_data_req_t,
    parameter type icache_data_res_t  = config_pkg::icache_data_res_t
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  icache_data_req_t            dreq_i,
    output icache_data_res_t            dreq_o,
    output logic                        mem_req_o,
    output logic [config_pkg::VLEN-1:0] mem_addr_o,
    input  logic                        mem_gnt_i,
    input  logic                        mem_rvalid_i,
    input  logic [31:0]                 mem_rdata_i
);

    localparam int unsigned VLEN   = config_pkg::VLEN;
    localparam int unsigned OFF    = offBits(LINE_WORDS);
    localparam int unsigned IDX    = idxBits(NUM_SETS);
    localparam int unsigned WORD_W = OFF - 2;
    localparam int unsigned TAG_W  = VLEN - IDX - OFF;
    localparam int unsigned CNT_W  = $clog2(LINE_WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] ALL_BEATS = CNT_W'(LINE_WORDS);

    icacheState_e                 state_q, state_d;
    logic                         s1Valid_q, s1Valid_d;
    logic                         s1Spec_q, s1Spec_d;
    logic [VLEN-1:0]              s1Vaddr_q, s1Vaddr_d;
    logic                         drop_q, drop_d;
    logic                         flushed_q, flushed_d;
    logic [CNT_W-1:0]             issueCnt_q, issueCnt_d;
    logic [CNT_W-1:0]             recvCnt_q, recvCnt_d;
    logic [LINE_WORDS-1:0][31:0]  lineBuf_q, lineBuf_d;

    logic [WORD_W-1:0]            s1Word;
    logic [IDX-1:0]               s1Index;
    logic [TAG_W-1:0]             s1Tag;
    logic                         rdValid;
    logic [TAG_W-1:0]             rdTag;
    logic [LINE_WORDS-1:0][31:0]  rdLine;
    logic                         lookupHit, lookupMiss, goMiss;
    logic                         ready, accept, lastBeat, install;
    logic                         respValid;
    logic [31:0]                  respWord;
    icache_data_res_t             res;

    assign s1Word  = s1Vaddr_q[OFF-1:2];
    assign s1Index = s1Vaddr_q[IDX+OFF-1:OFF];
    assign s1Tag   = s1Vaddr_q[VLEN-1:IDX+OFF];

    icache_array #(
        .NUM_SETS   (NUM_SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W),
        .IDX_W      (IDX)
    ) u_array (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (flush_i),
        .rdIdx_i    (s1Index),
        .rdValid_o  (rdValid),
        .rdTag_o    (rdTag),
        .rdLine_o   (rdLine),
        .we_i       (install),
        .wrIdx_i    (s1Index),
        .wrTag_i    (s1Tag),
        .wrLine_i   (lineBuf_d)
    );

    assign lookupHit  = s1Valid_q & (state_q == IDLE) & rdValid & (rdTag == s1Tag);
    assign lookupMiss = s1Valid_q & (state_q == IDLE) & ~lookupHit;
    assign goMiss     = lookupMiss & ~dreq_i.kill_s2;
    assign ready      = (state_q == IDLE) & ~lookupMiss;
    assign accept     = dreq_i.req & ready & ~dreq_i.kill_s1 & ~flush_i;
    assign lastBeat   = mem_rvalid_i & (recvCnt_q == LAST_BEAT);
    // kill_s2 only silences the response; a flush must also keep the stale line out of the array.
    assign install    = (state_q == REFILL) & lastBeat & ~flushed_q & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            s1Valid_q  <= 1'b0;
            s1Spec_q   <= 1'b0;
            s1Vaddr_q  <= '0;
            drop_q     <= 1'b0;
            flushed_q  <= 1'b0;
            issueCnt_q <= '0;
            recvCnt_q  <= '0;
            lineBuf_q  <= '0;
        end else begin
            state_q    <= state_d;
            s1Valid_q  <= s1Valid_d;
            s1Spec_q   <= s1Spec_d;
            s1Vaddr_q  <= s1Vaddr_d;
            drop_q     <= drop_d;
            flushed_q  <= flushed_d;
            issueCnt_q <= issueCnt_d;
            recvCnt_q  <= recvCnt_d;
            lineBuf_q  <= lineBuf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (goMiss) state_d = s1Spec_q ? UNCACHED : REFILL;
            REFILL:   if (lastBeat) state_d = RESP;
            UNCACHED: if (mem_rvalid_i) state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        s1Valid_d  = s1Valid_q;
        s1Spec_d   = s1Spec_q;
        s1Vaddr_d  = s1Vaddr_q;
        drop_d     = drop_q | ((dreq_i.kill_s2 | flush_i) & ((state_q != IDLE) | goMiss));
        flushed_d  = flushed_q | (flush_i & ((state_q != IDLE) | goMiss));
        issueCnt_d = issueCnt_q;
        recvCnt_d  = recvCnt_q;
        lineBuf_d  = lineBuf_q;

        if (state_q == IDLE && (lookupHit || dreq_i.kill_s2)) begin
            s1Valid_d = 1'b0;
        end
        if (state_q == RESP) begin
            s1Valid_d = 1'b0;
            drop_d    = 1'b0;
            flushed_d = 1'b0;
        end
        if (accept) begin
            s1Valid_d = 1'b1;
            s1Spec_d  = dreq_i.spec;
            s1Vaddr_d = dreq_i.vaddr;
        end

        // Uncached beats land in the slot of the requested word so RESP reads one place either way.
        if (state_q == REFILL || state_q == UNCACHED) begin
            if (mem_req_o && mem_gnt_i) begin
                issueCnt_d = issueCnt_q + 1'b1;
            end
            if (mem_rvalid_i) begin
                lineBuf_d[(state_q == REFILL) ? recvCnt_q[WORD_W-1:0] : s1Word] = mem_rdata_i;
                recvCnt_d = recvCnt_q + 1'b1;
            end
            if (state_d == RESP) begin
                issueCnt_d = '0;
                recvCnt_d  = '0;
            end
        end
    end

    always_comb begin
        respValid  = 1'b0;
        respWord   = '0;
        mem_req_o  = 1'b0;
        mem_addr_o = '0;

        if (lookupHit && !dreq_i.kill_s2) begin
            respValid = 1'b1;
            respWord  = rdLine[s1Word];
        end else if (state_q == RESP && !drop_q) begin
            respValid = 1'b1;
            respWord  = lineBuf_q[s1Word];
        end

        res       = '0;
        res.ready = ready;
        res.valid = respValid;
        if (respValid) begin
            res.data[31:0] = respWord;
            res.vaddr      = s1Vaddr_q;
        end

        case (state_q)
            REFILL: begin
                if (issueCnt_q < ALL_BEATS) begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = {s1Tag, s1Index, issueCnt_q[WORD_W-1:0], 2'b00};
                end
            end
            UNCACHED: begin
                if (issueCnt_q == '0) begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = {s1Vaddr_q[VLEN-1:2], 2'b00};
                end
            end
            default: ;
        endcase
    end

    assign dreq_o = res;

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed protocol scenarios plus randomized fetches against a line-level cache model.
module tb_icache_dm;

    localparam int unsigned NUM_SETS   = 64;
    localparam int unsigned LINE_BYTES = 16;

    logic                         clk = 1'b0;
    logic                         rstN = 1'b0;
    logic                         flushIn = 1'b0;
    config_pkg::icache_data_req_t dreqIn = '0;
    config_pkg::icache_data_res_t dreqOut;
    logic                         memReq;
    logic [31:0]                  memAddr;
    logic                         memGnt = 1'b0;
    logic                         memRvalid = 1'b0;
    logic [31:0]                  memRdata = '0;

    int          checks = 0;
    int          failures = 0;
    int unsigned cycleCnt = 0;
    int unsigned lastRvalidCycle = 0;
    int          gntStall = 0;
    logic [31:0] pendQ[$];
    logic [31:0] grantLog[$];

    bit          modelValid[NUM_SETS];
    int unsigned modelTag[NUM_SETS];

    icache_dm dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .flush_i      (flushIn),
        .dreq_i       (dreqIn),
        .dreq_o       (dreqOut),
        .mem_req_o    (memReq),
        .mem_addr_o   (memAddr),
        .mem_gnt_i    (memGnt),
        .mem_rvalid_i (memRvalid),
        .mem_rdata_i  (memRdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt = cycleCnt + 1;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        logic [31:0] a;
        a = addr - (addr % 4);
        return {a[7:0], a[15:8], a[23:16], a[31:24]} ^ 32'h5A3C_96E1;
    endfunction

    // In-order memory: random grant stalls, random return latency, sometimes same-cycle rvalid.
    always @(negedge clk) begin
        memGnt    = 1'b0;
        memRvalid = 1'b0;
        memRdata  = '0;
        if (pendQ.size() > 0 && $urandom_range(0, 2) != 0) begin
            memRvalid       = 1'b1;
            memRdata        = memWord(pendQ.pop_front());
            lastRvalidCycle = cycleCnt;
        end
        if (memReq) begin
            if (gntStall > 0) begin
                gntStall = gntStall - 1;
            end else if ($urandom_range(0, 3) != 0) begin
                memGnt = 1'b1;
                grantLog.push_back(memAddr);
                if (!memRvalid && pendQ.size() == 0 && $urandom_range(0, 1) == 1) begin
                    memRvalid       = 1'b1;
                    memRdata        = memWord(memAddr);
                    lastRvalidCycle = cycleCnt;
                end else begin
                    pendQ.push_back(memAddr);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit req, input bit killS1, input bit killS2, input bit spec,
                                 input logic [31:0] vaddr, input bit flush);
        @(negedge clk);
        dreqIn.req     = req;
        dreqIn.kill_s1 = killS1;
        dreqIn.kill_s2 = killS2;
        dreqIn.spec    = spec;
        dreqIn.vaddr   = vaddr;
        flushIn        = flush;
        #2;
    endtask

    function automatic bit modelHit(input logic [31:0] addr);
        int unsigned idx;
        idx = (addr / LINE_BYTES) % NUM_SETS;
        return modelValid[idx] && modelTag[idx] == addr / (LINE_BYTES * NUM_SETS);
    endfunction

    function automatic void modelInstall(input logic [31:0] addr);
        int unsigned idx;
        idx = (addr / LINE_BYTES) % NUM_SETS;
        modelValid[idx] = 1'b1;
        modelTag[idx]   = addr / (LINE_BYTES * NUM_SETS);
    endfunction

    function automatic void modelFlush();
        foreach (modelValid[i]) modelValid[i] = 1'b0;
    endfunction

    task automatic checkBeats(input string name, input int beatsBefore, input int expBeats,
                              input logic [31:0] addr, input bit single);
        logic [31:0] expAddr;
        checkOutput({name, ".beats"}, 64'(grantLog.size() - beatsBefore), 64'(expBeats));
        for (int i = 0; i < expBeats && beatsBefore + i < grantLog.size(); i++) begin
            expAddr = single ? addr - (addr % 4) : addr - (addr % LINE_BYTES) + 32'(4 * i);
            checkOutput({name, ".beatAddr"}, 64'(grantLog[beatsBefore + i]), 64'(expAddr));
        end
    endtask

    task automatic doFetch(input logic [31:0] addr, input bit spec, input string name);
        bit hit;
        bit gotResp;
        int expBeats;
        int beatsBefore;
        int waitCycles;
        hit         = modelHit(addr);
        expBeats    = hit ? 0 : (spec ? 1 : 4);
        beatsBefore = grantLog.size();
        applyStimulus(1'b1, 1'b0, 1'b0, spec, addr, 1'b0);
        checkOutput({name, ".ready"}, 64'(dreqOut.ready), 64'd1);
        gotResp    = 1'b0;
        waitCycles = 0;
        while (!gotResp && waitCycles < 60) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            waitCycles++;
            gotResp = dreqOut.valid;
        end
        checkOutput({name, ".valid"}, 64'(gotResp), 64'd1);
        if (hit) checkOutput({name, ".hitLatency"}, 64'(waitCycles), 64'd1);
        else     checkOutput({name, ".missLatency"}, 64'(cycleCnt), 64'(lastRvalidCycle + 1));
        checkOutput({name, ".data"}, dreqOut.data, {32'h0, memWord(addr)});
        checkOutput({name, ".vaddr"}, 64'(dreqOut.vaddr), 64'(addr));
        checkBeats(name, beatsBefore, expBeats, addr, spec);
        if (!hit && !spec) modelInstall(addr);
    endtask

    task automatic killedRefill(input logic [31:0] addr, input bit useFlush, input string name);
        bit sawValid;
        bit done;
        int beatsBefore;
        int waitCycles;
        beatsBefore = grantLog.size();
        gntStall    = 3;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, addr, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        sawValid = dreqOut.valid;
        applyStimulus(1'b0, 1'b0, !useFlush, 1'b0, 32'h0, useFlush);
        sawValid |= dreqOut.valid;
        done       = 1'b0;
        waitCycles = 0;
        while (!done && waitCycles < 80) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            waitCycles++;
            sawValid |= dreqOut.valid;
            done = dreqOut.ready && pendQ.size() == 0;
        end
        checkOutput({name, ".drained"}, 64'(done), 64'd1);
        checkOutput({name, ".noResp"}, 64'(sawValid), 64'd0);
        checkBeats(name, beatsBefore, 4, addr, 1'b0);
        if (useFlush) modelFlush();
        else          modelInstall(addr);
    endtask

    initial begin
        int beatsBefore;
        logic [31:0] addr;
        modelFlush();

        repeat (3) @(negedge clk);
        rstN = 1'b1;
        #2;
        checkOutput("reset.ready", 64'(dreqOut.ready), 64'd1);
        checkOutput("reset.valid", 64'(dreqOut.valid), 64'd0);
        checkOutput("reset.data", dreqOut.data, 64'd0);
        checkOutput("reset.vaddr", 64'(dreqOut.vaddr), 64'd0);
        checkOutput("reset.memReq", 64'(memReq), 64'd0);
        checkOutput("reset.memAddr", 64'(memAddr), 64'd0);

        doFetch(32'h8000_0000, 1'b0, "cold");
        doFetch(32'h8000_0004, 1'b0, "refetch");

        beatsBefore = grantLog.size();
        for (int i = 0; i <= 4; i++) begin
            applyStimulus(i < 4, 1'b0, 1'b0, 1'b0, 32'h8000_0000 + 32'(4 * i), 1'b0);
            if (i < 4) checkOutput("stream.ready", 64'(dreqOut.ready), 64'd1);
            if (i > 0) begin
                checkOutput("stream.valid", 64'(dreqOut.valid), 64'd1);
                checkOutput("stream.data", dreqOut.data, {32'h0, memWord(32'h8000_0000 + 32'(4 * (i - 1)))});
            end
        end
        checkOutput("stream.noTraffic", 64'(grantLog.size() - beatsBefore), 64'd0);

        doFetch(32'h8000_0100, 1'b1, "specMiss");
        doFetch(32'h8000_0100, 1'b0, "specRepeat");

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0008, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("killS2Idle.valid", 64'(dreqOut.valid), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("killS2Idle.after", 64'(dreqOut.valid), 64'd0);

        killedRefill(32'h8000_0200, 1'b0, "killS2Refill");
        doFetch(32'h8000_0208, 1'b0, "killS2Rehit");

        beatsBefore = grantLog.size();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("killS1.valid", 64'(dreqOut.valid), 64'd0);
        checkOutput("killS1.memReq", 64'(memReq), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("killS1.noTraffic", 64'(grantLog.size() - beatsBefore), 64'd0);

        // Three tags share each index so conflict misses and re-hits both occur.
        for (int n = 0; n < 30; n++) begin
            addr = 32'h8000_0000 + 32'($urandom_range(0, 2) * 1024) + 32'($urandom_range(0, 3) * 16)
                 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
                modelFlush();
            end
            doFetch(addr, $urandom_range(0, 3) == 0, "random");
        end

        doFetch(32'h8000_0000, 1'b0, "preFlush");
        killedRefill(32'h8000_0300, 1'b1, "flushRefill");
        doFetch(32'h8000_0300, 1'b0, "postFlushRefetch");
        doFetch(32'h8000_0000, 1'b0, "postFlushOldLine");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
